uart_cmd_bridge: RTL

- Host-side command initiator for the life engine.
- Deserialises 8N1 UART bytes from the host into framed command packets and drives the engine command port (cmd/cmd_arg0) with a valid/ready handshake.
- Returns one status byte per packet on the UART transmit line.
- Sits beside the button and switch command generators, with its cmd_valid ORed into the command mux.

---
 rtl/uart_cmd_bridge_if.sv | 12 +
 rtl/uart_cmd_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge_if.sv
// Engine command port: opcode plus 32-bit argument under a valid/ready handshake.
// Latency: wires only.
// Backpressure: the master holds cmd/cmd_arg0 stable while cmd_valid is high and cmd_ready is low.
interface uart_cmd_bridge_if;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (output cmd, output cmd_arg0, output cmd_valid, input cmd_ready);
  modport slave  (input cmd, input cmd_arg0, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART (8N1) to engine command bridge: 5-byte packets in, one status byte out per packet.
// Latency: cmd_valid 1 cycle after the last byte; ack start bit 2 cycles after the handshake.
// Backpressure: waits indefinitely for cmd_ready; extra bytes meanwhile flag overrun; TX drops when full.
module uart_cmd_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx_in,
  output logic              uart_tx_out,
  output logic              busy,
  uart_cmd_bridge_if.master cmd_if
);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ARG, P_ISSUE, P_ACK} pkt_state_t;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_d;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  pkt_state_t       state, state_nxt;
  logic [2:0]       arg_idx;
  logic [TO_W-1:0]  to_cnt;
  logic             overrun;
  logic [2:0]       opcode;
  logic [31:0]      arg;
  logic             hdr_ok, to_expire;
  logic             tx_req;
  logic [7:0]       tx_req_dat;

  logic             tx_active, pend_vld, tx_bit_end, tx_free;
  logic [7:0]       pend_dat;
  logic [9:0]       tx_frame;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_in;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver: half-bit start re-check, then mid-bit sampling of data and stop bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt     <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign hdr_ok    = (rx_shift[7:3] == 5'b10100);
  assign to_expire = (state == P_ARG) && (to_cnt == '0) && !byte_valid;

  // Packet FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= P_IDLE;
    else       state <= state_nxt;
  end

  // Packet FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE:  if (byte_valid && hdr_ok) state_nxt = P_ARG;
      P_ARG: begin
        if (byte_valid && arg_idx == 3'd4) state_nxt = P_ISSUE;
        else if (frame_err || to_expire)   state_nxt = P_IDLE;
      end
      P_ISSUE: if (cmd_if.cmd_ready) state_nxt = P_ACK;
      default: state_nxt = P_IDLE;
    endcase
  end

  // Packet FSM outputs: status byte requests towards the transmitter.
  always_comb begin
    tx_req     = 1'b0;
    tx_req_dat = 8'hEE;
    case (state)
      P_IDLE: tx_req = byte_valid && !hdr_ok;
      P_ARG: begin
        if (frame_err) begin
          tx_req = 1'b1;
        end else if (to_expire) begin
          tx_req     = 1'b1;
          tx_req_dat = 8'hED;
        end
      end
      P_ACK: begin
        tx_req     = 1'b1;
        tx_req_dat = (overrun || byte_valid) ? 8'hEF : {5'b10110, opcode};
      end
      default: ;
    endcase
  end

  assign cmd_if.cmd_valid = (state == P_ISSUE);
  assign cmd_if.cmd       = opcode;
  assign cmd_if.cmd_arg0  = arg;
  assign busy             = (state != P_IDLE);

  // Packet datapath: opcode/argument capture, inter-byte timeout, overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode  <= '0;
      arg     <= '0;
      arg_idx <= '0;
      to_cnt  <= '0;
      overrun <= 1'b0;
    end else begin
      if (byte_valid)                        to_cnt <= TO_W'(TO_CYCLES);
      else if (state == P_ARG && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
      case (state)
        P_IDLE: begin
          if (byte_valid && hdr_ok) begin
            opcode  <= rx_shift[2:0];
            arg_idx <= 3'd1;
          end
        end
        P_ARG: begin
          if (byte_valid) begin
            case (arg_idx)
              3'd1:    arg[7:0]   <= rx_shift;
              3'd2:    arg[15:8]  <= rx_shift;
              3'd3:    arg[23:16] <= rx_shift;
              default: arg[31:24] <= rx_shift;
            endcase
            arg_idx <= arg_idx + 1'b1;
          end
        end
        P_ISSUE: if (byte_valid) overrun <= 1'b1;
        default: overrun <= 1'b0;
      endcase
    end
  end

  assign tx_bit_end = tx_active && (tx_cnt == FULL_M1);
  assign tx_free    = !tx_active || (tx_bit_end && tx_bit == 4'd9);

  // Transmitter with a single pending byte; a new frame starts in the cycle the stop bit ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_tx_out <= 1'b1;
      tx_active   <= 1'b0;
      tx_frame    <= '1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      pend_vld    <= 1'b0;
      pend_dat    <= '0;
    end else begin
      if (tx_free && (pend_vld || tx_req)) begin
        tx_active   <= 1'b1;
        tx_cnt      <= '0;
        tx_bit      <= '0;
        uart_tx_out <= 1'b0;
        tx_frame    <= {1'b1, (pend_vld ? pend_dat : tx_req_dat), 1'b0};
      end else if (tx_free) begin
        tx_active   <= 1'b0;
        uart_tx_out <= 1'b1;
      end else if (tx_bit_end) begin
        tx_cnt      <= '0;
        tx_bit      <= tx_bit + 1'b1;
        uart_tx_out <= tx_frame[1];
        tx_frame    <= {1'b1, tx_frame[9:1]};
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (tx_free && pend_vld) begin
        pend_vld <= tx_req;
        if (tx_req) pend_dat <= tx_req_dat;
      end else if (!tx_free && !pend_vld && tx_req) begin
        pend_vld <= 1'b1;
        pend_dat <= tx_req_dat;
      end
    end
  end
endmodule
